// File: rtl/rv32ima_pkg.sv
// Shared types and encodings for the rv32ima memory controller.
package rv32ima_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned LDST_WIDTH_W = 2;
    typedef logic [LDST_WIDTH_W-1:0] ldst_width_t;

    localparam ldst_width_t LDST_BYTE    = 2'b00;
    localparam ldst_width_t LDST_HALF    = 2'b01;
    localparam ldst_width_t LDST_WORD    = 2'b10;
    localparam ldst_width_t LDST_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        RESP
    } mem_ctrl_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data accesses: byte enables, store replication,
// load right-justification and misalignment detection. Purely combinational.
module mem_lane_align
    import rv32ima_pkg::*;
(
    input  logic [1:0]  i_off,
    input  ldst_width_t i_width,
    input  word_t       i_store,
    input  word_t       i_rdata,
    output logic [3:0]  o_be,
    output word_t       o_wdata,
    output word_t       o_load,
    output logic        o_misalign
);

    word_t w_shifted;

    // Decode width into lane enables, replicated store data and aligned load data.
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = '0;
        o_load     = '0;
        o_misalign = 1'b0;
        w_shifted  = i_rdata >> {i_off, 3'b000};
        case (i_width)
            LDST_BYTE: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_store[7:0]}};
                o_load  = {24'h000000, w_shifted[7:0]};
            end
            LDST_HALF: begin
                o_be       = 4'b0011 << {i_off[1], 1'b0};
                o_wdata    = {2{i_store[15:0]}};
                o_load     = {16'h0000, w_shifted[15:0]};
                o_misalign = i_off[0];
            end
            LDST_WORD: begin
                o_be       = 4'b1111;
                o_wdata    = i_store;
                o_load     = i_rdata;
                o_misalign = |i_off;
            end
            default: begin
                // Illegal width is reported the same way as a misaligned access.
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrating memory controller: one instruction fetch port and one data
// load/store port share a single RAM with one command outstanding at a time.
module mem_ctrl
    import rv32ima_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // Instruction port
    input  logic        imem_ren,
    input  word_t       imem_addr,
    output word_t       imem_load,
    output logic        ihit,
    // Data port
    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  word_t       dmem_addr,
    input  word_t       dmem_store,
    input  ldst_width_t dmem_width,
    output word_t       dmem_load,
    output logic        dhit,
    output logic        dmem_err,
    // RAM port
    output logic [29:0] ram_addr,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [3:0]  ram_be,
    output word_t       ram_wdata,
    input  word_t       ram_rdata,
    input  logic        ram_ready
);

    mem_ctrl_state_t r_state;
    logic            r_last_data;   // previous grant went to the data port
    logic [1:0]      r_off;
    ldst_width_t     r_width;
    logic            r_is_store;
    logic            r_conflict;    // ren and wen were both asserted at grant

    logic        r_ihit;
    logic        r_dhit;
    logic        r_dmem_err;
    word_t       r_imem_load;
    word_t       r_dmem_load;
    logic [29:0] r_ram_addr;
    logic        r_ram_ren;
    logic        r_ram_wen;
    logic [3:0]  r_ram_be;
    word_t       r_ram_wdata;

    logic        w_dreq;
    logic        w_grant_data;
    logic [1:0]  w_lane_off;
    ldst_width_t w_lane_width;
    logic [3:0]  w_be;
    word_t       w_wdata;
    word_t       w_load;
    logic        w_misalign;
    logic        w_unused_iaddr;

    assign w_dreq       = dmem_ren | dmem_wen;
    // Data wins unless it also won last time and a fetch is waiting.
    assign w_grant_data = w_dreq & ~(imem_ren & r_last_data);

    // In IDLE the lane logic sees the live request; afterwards the latched one.
    assign w_lane_off   = (r_state == IDLE) ? dmem_addr[1:0] : r_off;
    assign w_lane_width = (r_state == IDLE) ? dmem_width     : r_width;

    // Fetches are always whole words.
    assign w_unused_iaddr = ^imem_addr[1:0];

    mem_lane_align u_lane (
        .i_off      (w_lane_off),
        .i_width    (w_lane_width),
        .i_store    (dmem_store),
        .i_rdata    (ram_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_load     (w_load),
        .o_misalign (w_misalign)
    );

    // Controller FSM with registered RAM commands and response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last_data <= 1'b0;
            r_off       <= 2'b00;
            r_width     <= LDST_BYTE;
            r_is_store  <= 1'b0;
            r_conflict  <= 1'b0;
            r_ihit      <= 1'b0;
            r_dhit      <= 1'b0;
            r_dmem_err  <= 1'b0;
            r_imem_load <= '0;
            r_dmem_load <= '0;
            r_ram_addr  <= '0;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_be    <= 4'b0000;
            r_ram_wdata <= '0;
        end else begin
            r_ihit     <= 1'b0;
            r_dhit     <= 1'b0;
            r_dmem_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_data) begin
                        r_last_data <= 1'b1;
                        r_off       <= dmem_addr[1:0];
                        r_width     <= dmem_width;
                        r_is_store  <= dmem_wen;
                        r_conflict  <= dmem_ren & dmem_wen;
                        if (w_misalign) begin
                            r_dhit      <= 1'b1;
                            r_dmem_err  <= 1'b1;
                            r_dmem_load <= '0;
                            r_state     <= RESP;
                        end else begin
                            r_ram_addr  <= dmem_addr[31:2];
                            r_ram_be    <= w_be;
                            r_ram_wdata <= w_wdata;
                            r_ram_wen   <= dmem_wen;
                            r_ram_ren   <= ~dmem_wen;
                            r_state     <= DACC;
                        end
                    end else if (imem_ren) begin
                        r_last_data <= 1'b0;
                        r_ram_addr  <= imem_addr[31:2];
                        r_ram_be    <= 4'b1111;
                        r_ram_ren   <= 1'b1;
                        r_ram_wen   <= 1'b0;
                        r_state     <= IACC;
                    end
                end
                IACC: begin
                    if (ram_ready) begin
                        r_ram_ren   <= 1'b0;
                        r_imem_load <= ram_rdata;
                        r_ihit      <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                DACC: begin
                    if (ram_ready) begin
                        r_ram_ren  <= 1'b0;
                        r_ram_wen  <= 1'b0;
                        if (!r_is_store) begin
                            r_dmem_load <= w_load;
                        end
                        r_dhit     <= 1'b1;
                        r_dmem_err <= r_conflict;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ihit      = r_ihit;
    assign dhit      = r_dhit;
    assign dmem_err  = r_dmem_err;
    assign imem_load = r_imem_load;
    assign dmem_load = r_dmem_load;
    assign ram_addr  = r_ram_addr;
    assign ram_ren   = r_ram_ren;
    assign ram_wen   = r_ram_wen;
    assign ram_be    = r_ram_be;
    assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl.
module tb_mem_ctrl;
    import rv32ima_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ren;
    word_t       imem_addr;
    word_t       imem_load;
    logic        ihit;
    logic        dmem_ren;
    logic        dmem_wen;
    word_t       dmem_addr;
    word_t       dmem_store;
    ldst_width_t dmem_width;
    word_t       dmem_load;
    logic        dhit;
    logic        dmem_err;
    logic [29:0] ram_addr;
    logic        ram_ren;
    logic        ram_wen;
    logic [3:0]  ram_be;
    word_t       ram_wdata;
    word_t       ram_rdata;
    logic        ram_ready;

    int n_checks = 0;
    int n_err    = 0;

    mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .imem_ren   (imem_ren),
        .imem_addr  (imem_addr),
        .imem_load  (imem_load),
        .ihit       (ihit),
        .dmem_ren   (dmem_ren),
        .dmem_wen   (dmem_wen),
        .dmem_addr  (dmem_addr),
        .dmem_store (dmem_store),
        .dmem_width (dmem_width),
        .dmem_load  (dmem_load),
        .dhit       (dhit),
        .dmem_err   (dmem_err),
        .ram_addr   (ram_addr),
        .ram_ren    (ram_ren),
        .ram_wen    (ram_wen),
        .ram_be     (ram_be),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        imem_ren   = 1'b0;
        imem_addr  = '0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = '0;
        dmem_store = '0;
        dmem_width = LDST_WORD;
        ram_rdata  = '0;
        ram_ready  = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_ihit", {31'b0, ihit}, 32'd0);
        check("rst_dhit", {31'b0, dhit}, 32'd0);
        check("rst_err", {31'b0, dmem_err}, 32'd0);
        check("rst_ren", {31'b0, ram_ren}, 32'd0);
        check("rst_wen", {31'b0, ram_wen}, 32'd0);
        check("rst_be", {28'b0, ram_be}, 32'd0);
        check("rst_addr", {2'b0, ram_addr}, 32'd0);
        check("rst_wdata", ram_wdata, 32'd0);
        check("rst_iload", imem_load, 32'd0);
        check("rst_dload", dmem_load, 32'd0);
        rst = 1'b0;

        // Fetch at 0x100: command next cycle, hit two cycles after request
        imem_ren  = 1'b1;
        imem_addr = 32'h0000_0100;
        ram_rdata = 32'h0050_0093;
        tick();
        check("fetch_ren", {31'b0, ram_ren}, 32'd1);
        check("fetch_addr", {2'b0, ram_addr}, 32'h40);
        check("fetch_be", {28'b0, ram_be}, 32'hF);
        check("fetch_early_hit", {31'b0, ihit}, 32'd0);
        imem_ren = 1'b0;    // withdrawn mid-access
        tick();
        check("fetch_ihit", {31'b0, ihit}, 32'd1);
        check("fetch_iload", imem_load, 32'h0050_0093);
        check("fetch_ren_drop", {31'b0, ram_ren}, 32'd0);
        tick();
        check("fetch_ihit_pulse", {31'b0, ihit}, 32'd0);
        check("fetch_iload_hold", imem_load, 32'h0050_0093);

        // Both ports held: grants alternate D, I, D, I (3 cycles per access)
        imem_ren   = 1'b1;
        imem_addr  = 32'h0000_0100;
        dmem_ren   = 1'b1;
        dmem_addr  = 32'h0000_0300;
        dmem_width = LDST_WORD;
        ram_rdata  = 32'hCAFE_F00D;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k % 3 == 2) begin
                check($sformatf("alt_hits_%0d", k), {30'b0, ihit, dhit},
                      (k == 5 || k == 11) ? 32'd2 : 32'd1);
            end
        end
        imem_ren = 1'b0;
        dmem_ren = 1'b0;
        tick();
        check("alt_idle_hits", {30'b0, ihit, dhit}, 32'd0);

        // Byte store 0xAB at 0x203
        dmem_wen   = 1'b1;
        dmem_addr  = 32'h0000_0203;
        dmem_width = LDST_BYTE;
        dmem_store = 32'h0000_00AB;
        tick();
        check("sb_wen", {31'b0, ram_wen}, 32'd1);
        check("sb_ren", {31'b0, ram_ren}, 32'd0);
        check("sb_be", {28'b0, ram_be}, 32'h8);
        check("sb_wdata", ram_wdata, 32'hABAB_ABAB);
        check("sb_addr", {2'b0, ram_addr}, 32'h80);
        dmem_wen = 1'b0;
        tick();
        check("sb_dhit", {30'b0, dhit, dmem_err}, 32'd2);
        check("sb_wen_drop", {31'b0, ram_wen}, 32'd0);
        tick();

        // Half load at 0x202 from 0x12345678
        dmem_ren   = 1'b1;
        dmem_addr  = 32'h0000_0202;
        dmem_width = LDST_HALF;
        ram_rdata  = 32'h1234_5678;
        tick();
        check("lh_ren", {31'b0, ram_ren}, 32'd1);
        check("lh_be", {28'b0, ram_be}, 32'hC);
        dmem_ren = 1'b0;
        tick();
        check("lh_dhit", {30'b0, dhit, dmem_err}, 32'd2);
        check("lh_load", dmem_load, 32'h0000_1234);
        tick();

        // Byte load at 0x201 from 0x12345678
        dmem_ren   = 1'b1;
        dmem_addr  = 32'h0000_0201;
        dmem_width = LDST_BYTE;
        tick();
        check("lb_be", {28'b0, ram_be}, 32'h2);
        dmem_ren = 1'b0;
        tick();
        check("lb_load", dmem_load, 32'h0000_0056);
        tick();

        // Misaligned word load at 0x201: no command, immediate error response
        dmem_ren   = 1'b1;
        dmem_addr  = 32'h0000_0201;
        dmem_width = LDST_WORD;
        tick();
        check("mis_ren", {31'b0, ram_ren}, 32'd0);
        check("mis_hit_err", {30'b0, dhit, dmem_err}, 32'd3);
        check("mis_load", dmem_load, 32'd0);
        dmem_ren = 1'b0;
        tick();
        check("mis_pulse", {30'b0, dhit, dmem_err}, 32'd0);

        // Illegal width
        dmem_ren   = 1'b1;
        dmem_addr  = 32'h0000_0200;
        dmem_width = LDST_ILLEGAL;
        tick();
        check("ill_hit_err", {30'b0, dhit, dmem_err}, 32'd3);
        check("ill_ren", {31'b0, ram_ren}, 32'd0);
        dmem_ren = 1'b0;
        tick();

        // ren and wen together: performed as store, error flagged
        dmem_ren   = 1'b1;
        dmem_wen   = 1'b1;
        dmem_addr  = 32'h0000_0204;
        dmem_width = LDST_WORD;
        dmem_store = 32'hDEAD_BEEF;
        tick();
        check("both_wen_ren", {30'b0, ram_wen, ram_ren}, 32'd2);
        check("both_wdata", ram_wdata, 32'hDEAD_BEEF);
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
        tick();
        check("both_hit_err", {30'b0, dhit, dmem_err}, 32'd3);
        tick();

        // Stalled store: ram_ready low 5 cycles, inputs changed mid-access
        ram_ready  = 1'b0;
        dmem_wen   = 1'b1;
        dmem_addr  = 32'h0000_0208;
        dmem_store = 32'h1122_3344;
        tick();
        dmem_wen   = 1'b0;
        dmem_addr  = 32'h0000_0400;
        dmem_store = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_wen_%0d", i), {31'b0, ram_wen}, 32'd1);
            check($sformatf("stall_addr_%0d", i), {2'b0, ram_addr}, 32'h82);
            check($sformatf("stall_dhit_%0d", i), {31'b0, dhit}, 32'd0);
            tick();
        end
        ram_ready = 1'b1;
        check("stall_wen_last", {31'b0, ram_wen}, 32'd1);
        check("stall_wdata", ram_wdata, 32'h1122_3344);
        tick();
        check("stall_dhit", {31'b0, dhit}, 32'd1);
        check("stall_wen_drop", {31'b0, ram_wen}, 32'd0);
        tick();
        check("stall_dhit_once", {31'b0, dhit}, 32'd0);

        // Repeat, reset in cycle 3: access abandoned, late ready ignored
        ram_ready = 1'b0;
        dmem_wen  = 1'b1;
        dmem_addr = 32'h0000_0208;
        tick();
        dmem_wen = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_wen", {31'b0, ram_wen}, 32'd0);
        check("rst_mid_dhit", {31'b0, dhit}, 32'd0);
        check("rst_mid_addr", {2'b0, ram_addr}, 32'd0);
        rst       = 1'b0;
        ram_ready = 1'b1;
        tick();
        check("late_ready_hit", {30'b0, ihit, dhit}, 32'd0);
        check("late_ready_cmd", {30'b0, ram_wen, ram_ren}, 32'd0);
        tick();
        check("late_ready_hit2", {30'b0, ihit, dhit}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 mem_ctrl SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 Instruction port SHALL be: imem_ren in 1 fetch request; imem_addr in 32 byte address; imem_load out 32 fetched word; ihit out 1 one-cycle completion pulse.
REQ-003 Data port SHALL be: dmem_ren in 1; dmem_wen in 1; dmem_addr in 32; dmem_store in 32 store data, right-justified; dmem_width in LDST_WIDTH_W (00 byte, 01 half, 10 word, 11 illegal); dmem_load out 32 right-justified, zero-padded; dhit out 1 pulse; dmem_err out 1 pulse.
REQ-004 RAM port SHALL be: ram_addr out 30 word address; ram_ren out 1; ram_wen out 1; ram_be out 4 byte enables; ram_wdata out 32; ram_rdata in 32; ram_ready in 1 completion strobe, valid in any cycle of a command.

Function
REQ-005 FSM states SHALL be IDLE, IACC, DACC, RESP; exactly one RAM command is outstanding at a time.
REQ-006 IDLE: on dmem_ren|dmem_wen go to DACC; else on imem_ren go to IACC; else stay.
REQ-007 Both ports pending in IDLE: grant data, unless the previous grant was data, then grant instruction (alternation, no starvation).
REQ-008 On grant, address, width, store data and direction SHALL be latched; later request-input changes SHALL NOT affect the access in flight.
REQ-009 IACC/DACC: ram_ren or ram_wen held high with stable ram_addr/ram_be/ram_wdata until the cycle ram_ready=1; then ram_rdata is captured and state goes to RESP.
REQ-010 RESP: ihit or dhit high for exactly one cycle with imem_load/dmem_load valid that cycle; next state IDLE; load outputs hold last value otherwise.
REQ-011 With ram_ready tied high, request seen in IDLE at cycle N SHALL produce hit at cycle N+2.
REQ-012 Byte enables: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'b1111.
REQ-013 Store data SHALL be replicated per lane (byte x4, half x2); loads SHALL be shifted right by the lane offset and zero-padded above the access width (sign extension belongs to the requester).
REQ-014 Misaligned half (addr[0]=1) or word (addr[1:0]!=0), or width 11: no RAM command, go directly to RESP, dhit and dmem_err pulse together, dmem_load=0.
REQ-015 dmem_ren and dmem_wen both high: treated as store, dmem_err pulses with dhit.
REQ-016 Request withdrawn mid-access: access completes and the hit still pulses.
REQ-017 Requests arriving in RESP SHALL be ignored until IDLE; a request held through RESP is served again (requester deasserts after hit).

Reset
REQ-018 rst SHALL force IDLE, previous-grant=instruction, and all outputs (ihit, dhit, dmem_err, ram_ren, ram_wen, ram_be, ram_addr, ram_wdata, imem_load, dmem_load) to 0 on the next edge.
REQ-019 rst during IACC/DACC/RESP SHALL abandon the access with no hit pulse; a late ram_ready after reset SHALL be ignored.

Structure
REQ-020 word_t, LDST_WIDTH_W, width encodings and mem_ctrl_state_t SHALL live in rv32ima_pkg.
REQ-021 Lane logic (byte enables, store replication, load shift, misalign detect) SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-022 ram_ready=1, imem_ren addr 0x100, RAM word 0x00500093 -> ram_ren next cycle, ihit with imem_load=0x00500093 two cycles after request.
REQ-023 imem_ren and dmem_ren same cycle, both held -> data served first, instruction next; twice more -> grants alternate D,I,D,I.
REQ-024 byte store 0xAB at 0x203 -> ram_be=1000, ram_wdata=0xABABABAB; half load at 0x202 from word 0x12345678 -> dmem_load=0x00001234.
REQ-025 word load at 0x201 -> no ram_ren, dhit+dmem_err next+1 cycle, dmem_load=0.
REQ-026 ram_ready low 5 cycles during DACC -> ram_wen and ram_addr stable 6 cycles, dhit once; rst in cycle 3 of a repeat -> no dhit, ram_wen=0 after reset edge.
